// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared note codes, nominal half-periods and FSM states for the buzzer tone path
package tone_pkg;

    localparam int CNT_W       = 22;
    localparam int HALF_LA_NOM = 56_819;
    localparam int HALF_DO_NOM = 95_556;

    // NOTE_NONE doubles as the "other" classification of a measured half-period
    typedef enum logic [1:0] {
        NOTE_NONE = 2'b00,
        NOTE_LA   = 2'b01,
        NOTE_DO   = 2'b10
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARM   = 2'b01,
        ST_TRACK = 2'b10
    } state_t;

endpackage

// File: rtl/tone_classifier.sv
// rtl/tone_classifier.sv - combinational half-period classifier: LA, DO or other (NOTE_NONE)
module tone_classifier
    import tone_pkg::*;
#(
    parameter int HALF_LA = HALF_LA_NOM,
    parameter int HALF_DO = HALF_DO_NOM,
    parameter int TOL     = 2_048
) (
    input  logic [CNT_W-1:0] i_m,
    output note_t            o_class
);

    localparam int W1 = CNT_W + 1;
    localparam logic signed [W1-1:0] LA_S  = W1'(HALF_LA);
    localparam logic signed [W1-1:0] DO_S  = W1'(HALF_DO);
    localparam logic        [W1-1:0] TOL_U = W1'(TOL);

    logic signed [W1-1:0] w_d_la;
    logic signed [W1-1:0] w_d_do;
    logic        [W1-1:0] w_a_la;
    logic        [W1-1:0] w_a_do;

    always_comb begin
        // one extra bit keeps the difference signed without wrap
        w_d_la  = $signed({1'b0, i_m}) - LA_S;
        w_d_do  = $signed({1'b0, i_m}) - DO_S;
        w_a_la  = w_d_la[W1-1] ? $unsigned(-w_d_la) : $unsigned(w_d_la);
        w_a_do  = w_d_do[W1-1] ? $unsigned(-w_d_do) : $unsigned(w_d_do);
        o_class = NOTE_NONE;
        if (w_a_la <= TOL_U) begin
            o_class = NOTE_LA;
        end else if (w_a_do <= TOL_U) begin
            o_class = NOTE_DO;
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - buzzer tone half-period decoder; TONE_DEC_GLITCH_EN adds a 3-sample input filter
module tone_decoder
    import tone_pkg::*;
#(
    parameter int HALF_LA = HALF_LA_NOM,
    parameter int HALF_DO = HALF_DO_NOM,
    parameter int TOL     = 2_048,
    parameter int CONFIRM = 4,
    parameter int TIMEOUT = 2_500_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tone_in,
    output logic [1:0]       o_note,
    output logic             o_note_valid,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_half_period
);

    localparam int MW = $clog2(CONFIRM + 1);
    localparam logic [MW-1:0]    CONF_M    = MW'(CONFIRM);
    localparam logic [MW-1:0]    ONE_M     = MW'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_edge;
    logic             w_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    state_t           r_state, w_state;
    note_t            r_cand, w_cand;
    note_t            r_note, w_note;
    logic [MW-1:0]    r_match, w_match;
    logic             r_valid, w_valid;
    logic             r_locked;
    note_t            w_class;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_tone_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef TONE_DEC_GLITCH_EN
    logic r_h0;
    logic r_h1;
    logic r_filt;
    logic w_stable;

    // the filtered level only follows the synchronizer after three identical samples
    assign w_stable = (r_sync2 == r_h0) && (r_h0 == r_h1);
    assign w_edge   = w_stable && (r_sync2 != r_filt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h0   <= 1'b0;
            r_h1   <= 1'b0;
            r_filt <= 1'b0;
        end else begin
            r_h0 <= r_sync2;
            r_h1 <= r_h0;
            if (w_stable) begin
                r_filt <= r_sync2;
            end
        end
    end
`else
    logic r_prev;

    assign w_edge = r_sync2 ^ r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= r_sync2;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_half <= '0;
        end else if (w_edge) begin
            r_half <= r_cnt;
            r_cnt  <= CNT_W'(1);
        end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    tone_classifier #(
        .HALF_LA (HALF_LA),
        .HALF_DO (HALF_DO),
        .TOL     (TOL)
    ) u_classifier (
        .i_m     (r_cnt),
        .o_class (w_class)
    );

    assign w_timeout = (r_cnt == TIMEOUT_C);

    always_comb begin
        w_state = r_state;
        w_cand  = r_cand;
        w_match = r_match;
        w_note  = r_note;
        w_valid = 1'b0;
        if (w_edge) begin
            // an edge takes priority over a coincident timeout
            case (r_state)
                ST_IDLE: begin
                    w_state = ST_ARM;
                end
                ST_ARM: begin
                    w_state = ST_TRACK;
                    w_cand  = w_class;
                    w_match = ONE_M;
                end
                default: begin
                    if (w_class == r_cand) begin
                        w_match = (r_match >= CONF_M) ? CONF_M : r_match + ONE_M;
                    end else begin
                        w_cand  = w_class;
                        w_match = ONE_M;
                    end
                end
            endcase
            if (r_state != ST_IDLE && w_match == CONF_M) begin
                if (w_cand != NOTE_NONE && w_cand != r_note) begin
                    w_note  = w_cand;
                    w_valid = 1'b1;
                end else if (w_cand == NOTE_NONE && r_note != NOTE_NONE) begin
                    w_note  = NOTE_NONE;
                    w_valid = 1'b1;
                end
            end
        end else if (w_timeout) begin
            w_state = ST_IDLE;
            w_match = '0;
            if (r_note != NOTE_NONE) begin
                w_note  = NOTE_NONE;
                w_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cand   <= NOTE_NONE;
            r_match  <= '0;
            r_note   <= NOTE_NONE;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cand   <= w_cand;
            r_match  <= w_match;
            r_note   <= w_note;
            r_valid  <= w_valid;
            r_locked <= (w_note != NOTE_NONE);
        end
    end

    assign o_note        = r_note;
    assign o_note_valid  = r_valid;
    assign o_locked      = r_locked;
    assign o_half_period = r_half;

endmodule

// File: doc/tone_decoder.md
# tone_decoder

Receive-side decoder for the drum-toy buzzer tone. Samples a square-wave input, such as a comparator or microphone front-end on the buzzer net, and measures each half-period in 50 MHz clock cycles. It classifies the tone as LA (440 Hz, count-up mode) or DO (261.63 Hz, count-down mode) and reports a debounced note code. It lets a second board recover the drum's counting direction from sound alone.

## Interface
- HALF_LA, default 56_819: nominal LA half-period in CLK cycles.
- HALF_DO, default 95_556: nominal DO half-period in CLK cycles.
- TOL, default 2_048: accepted ± deviation, in cycles, from either nominal.
- CONFIRM, default 4: consecutive equal classifications needed to change NOTE.
- TIMEOUT, default 2_500_000: cycles without an edge (50 ms) before silence is declared.
- CLK  in  1  50 MHz system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- TONE_IN  in  1  asynchronous square-wave tone input.
- NOTE  out  2  decoded note: 00 none, 01 LA, 10 DO; 11 never driven.
- NOTE_VALID  out  1  one-cycle pulse on every NOTE change.
- LOCKED  out  1  high while NOTE ≠ 00.
- HALF_PERIOD  out  22  last measured half-period in cycles (debug).

## Operation
- **Input path:** TONE_IN passes through a 2-FF synchronizer, then a registered copy for edge detect. Both rising and falling edges count.
- **Counter:** 22-bit half-period counter `cnt`, incremented every cycle and saturating at 2^22−1. On an edge cycle, `cnt` is captured into HALF_PERIOD and reloaded with 1.
- **Classification of a captured value `m`:**
  - LA if |m−HALF_LA| ≤ TOL.
  - else DO if |m−HALF_DO| ≤ TOL.
  - else OTHER.
  - Arithmetic uses 23-bit signed differences, so there is no wrap.
- **FSM states:** IDLE, ARM, TRACK.
  - IDLE → ARM on the first edge. That measurement is discarded because the counter is stale.
  - ARM → TRACK on the next edge. The first measurement is classified: `cand` = class, `match` = 1.
  - TRACK, on each edge:
    - If class == `cand`, `match` increments, saturating at CONFIRM.
    - Otherwise `cand` = class and `match` = 1.
    - When `match` reaches CONFIRM:
      - `cand` LA or DO and ≠ NOTE: NOTE ← `cand`, pulse NOTE_VALID.
      - `cand` OTHER and NOTE ≠ 00: NOTE ← 00, pulse NOTE_VALID.
  - Any state: when `cnt` reaches TIMEOUT without an edge, go to IDLE and clear `match`. If NOTE ≠ 00, also set NOTE ← 00 and pulse NOTE_VALID.
- **Direct note changes:** an LA→DO change goes straight from 01 to 10 with no intermediate 00, and produces one pulse.
- **Edge and timeout together:** if an edge and the timeout fall in the same cycle, the edge wins.

## Timing
- **Reset values:** NOTE=00, NOTE_VALID=0, LOCKED=0, HALF_PERIOD=0, FSM=IDLE, `cnt`=0, `cand`=OTHER, `match`=0.
- **Pin to edge:** a TONE_IN transition is seen as an edge 3 cycles later (2 sync stages + edge register).
- **Edge to outputs:**
  - HALF_PERIOD updates 1 cycle after the edge cycle.
  - NOTE, NOTE_VALID and LOCKED update 1 cycle after the confirming edge cycle. All outputs are registered.
- **Minimum lock latency:** 1 arming edge plus CONFIRM measured half-periods. For LA with defaults this is about 5 × 56_819 cycles.
- **Reset mid-lock:** asynchronous return to reset values. Lock-up restarts from IDLE once RST_N is released.

## Configuration
- Macro `TONE_DEC_GLITCH_EN`.
- **Defined:** a 3-sample majority/stability filter sits after the synchronizer. The filtered level changes only after 3 identical consecutive samples. This adds 2 cycles of pin-to-edge latency, and pulses of 1–2 cycles are ignored.
- **Undefined:** synchronizer output feeds edge detect directly.

## Structure
- **Shared package `tone_pkg`:**
  - note codes NOTE_NONE / NOTE_LA / NOTE_DO.
  - the nominal half-period constants, which the buzzer generator also uses.
  - the FSM state enum.
  - counter width = 22.
- **Sub-module `tone_classifier`:** purely combinational, `m` → class, parameterised by HALF_LA / HALF_DO / TOL.
- The top level holds the synchronizer, counter, FSM and output registers.

## Test plan
- 440 Hz square wave (toggle every 56_819 cycles): NOTE=01 and one NOTE_VALID pulse after the 5th edge plus 4 cycles; LOCKED=1; HALF_PERIOD=56_819.
- 261.63 Hz (toggle every 95_556 cycles): NOTE=10 after 5 edges; a 1_500-cycle jitter on alternate halves still locks.
- 1 kHz (toggle every 25_000 cycles): NOTE stays 00, no pulses.
- Lock LA, then switch to DO: NOTE goes 01→10 directly after 4 DO half-periods, exactly one pulse.
- Lock LA, then hold TONE_IN static: NOTE=00 with one pulse 2_500_000 cycles after the last edge (+1); FSM back to IDLE.
- RST_N low mid-lock → all outputs 0 immediately. With `TONE_DEC_GLITCH_EN`, 2-cycle glitches injected into a 440 Hz stream do not disturb the lock.
